// File: rtl/axi_chan_buffer.sv
// ---------------------------------------------------------------------------
// axi_chan_buffer
//
// Generic buffer for a single AXI4 channel (AW, W, B, AR or R). The caller
// packs the whole channel payload into one vector. The buffer can be built
// as a combinational passthrough, a 2-entry skid register slice or a
// first-word fall-through FIFO. It also reports occupancy, runs a stall
// watchdog on the downstream side and checks upstream handshake stability.
//
// Parameters:
//   PAYLOAD_W  packed payload width in bits (>= 1)
//   MODE       0 = passthrough, 1 = skid slice, 2 = FIFO
//   DEPTH      FIFO entries for MODE 2 (power of 2, >= 2)
//   MAXWAITS   stall watchdog threshold in cycles, 0 disables it
//   LVL_W      occupancy width, derived from DEPTH
//
// Ports:
//   aclk, areset          clock, synchronous active-high reset
//   s_valid/s_ready       upstream handshake, s_payload upstream data
//   m_valid/m_ready       downstream handshake, m_payload downstream data
//   level                 entries currently held (always 0 in MODE 0)
//   stall_err             sticky, m_valid stuck without m_ready too long
//   proto_err             sticky, upstream withdrew or altered a pending beat
// ---------------------------------------------------------------------------
module axi_chan_buffer #(
    parameter int PAYLOAD_W = 64,
    parameter int MODE      = 1,
    parameter int DEPTH     = 4,
    parameter int MAXWAITS  = 16,
    parameter int LVL_W     = $clog2(DEPTH + 1)
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [PAYLOAD_W-1:0] s_payload,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [PAYLOAD_W-1:0] m_payload,
    output logic [LVL_W-1:0]     level,
    output logic                 stall_err,
    output logic                 proto_err
);

    // Upstream stability checker: remember whether the previous cycle ended
    // with a beat offered but not taken, and what that beat carried. The
    // source must keep offering that exact beat until it is accepted.
    logic                 pend_q;
    logic [PAYLOAD_W-1:0] pend_payload_q;
    logic                 proto_err_q;

    always_ff @(posedge aclk) begin
        if (areset) begin
            pend_q         <= 1'b0;
            pend_payload_q <= '0;
            proto_err_q    <= 1'b0;
        end else begin
            if (pend_q && (!s_valid || (s_payload != pend_payload_q))) begin
                proto_err_q <= 1'b1;
            end
            pend_q         <= s_valid && !s_ready;
            pend_payload_q <= s_payload;
        end
    end

    assign proto_err = proto_err_q;

    // Stall watchdog. The counter saturates at MAXWAITS so it can never wrap
    // back and hide a long stall; the error flag is raised on the edge that
    // brings the count to MAXWAITS.
    generate
        if (MAXWAITS > 0) begin : g_wd
            localparam int WD_W = $clog2(MAXWAITS + 1);
            logic [WD_W-1:0] wd_cnt_q;
            logic            stall_err_q;

            always_ff @(posedge aclk) begin
                if (areset) begin
                    wd_cnt_q    <= '0;
                    stall_err_q <= 1'b0;
                end else if (m_valid && !m_ready) begin
                    if (wd_cnt_q != WD_W'(MAXWAITS)) begin
                        wd_cnt_q <= wd_cnt_q + 1'b1;
                    end
                    if (wd_cnt_q == WD_W'(MAXWAITS - 1)) begin
                        stall_err_q <= 1'b1;
                    end
                end else begin
                    wd_cnt_q <= '0;
                end
            end

            assign stall_err = stall_err_q;
        end else begin : g_no_wd
            assign stall_err = 1'b0;
        end
    endgenerate

    generate
        if (MODE == 1) begin : g_skid
            // Two-entry register slice. out_* is the entry presented
            // downstream, skid_* catches the beat that was already accepted
            // when the downstream stalled. Both handshake outputs come
            // straight from flops so the two sides are fully decoupled.
            logic                 out_valid_q;
            logic                 skid_valid_q;
            logic                 rdy_q;
            logic [PAYLOAD_W-1:0] out_q;
            logic [PAYLOAD_W-1:0] skid_q;
            logic                 s_hs;
            logic                 m_hs;

            assign s_hs = s_valid && rdy_q;
            assign m_hs = out_valid_q && m_ready;

            // When the output entry frees up it is refilled from the skid
            // entry first, otherwise from the upstream beat. The skid entry
            // only fills while the output entry is held, and s_ready drops
            // from the following cycle.
            always_ff @(posedge aclk) begin
                if (areset) begin
                    out_valid_q  <= 1'b0;
                    skid_valid_q <= 1'b0;
                    rdy_q        <= 1'b0;
                    out_q        <= '0;
                    skid_q       <= '0;
                end else if (!out_valid_q || m_hs) begin
                    if (skid_valid_q) begin
                        out_q        <= skid_q;
                        out_valid_q  <= 1'b1;
                        skid_valid_q <= 1'b0;
                    end else begin
                        out_valid_q <= s_hs;
                        if (s_hs) begin
                            out_q <= s_payload;
                        end
                    end
                    rdy_q <= 1'b1;
                end else if (s_hs) begin
                    skid_q       <= s_payload;
                    skid_valid_q <= 1'b1;
                    rdy_q        <= 1'b0;
                end
            end

            assign s_ready   = rdy_q;
            assign m_valid   = out_valid_q;
            assign m_payload = out_q;
            assign level     = LVL_W'(out_valid_q) + LVL_W'(skid_valid_q);
        end else if (MODE == 2) begin : g_fifo
            // First-word fall-through FIFO. Pointers are LVL_W wide and wrap
            // explicitly at DEPTH; only their low bits address the storage.
            // Full/empty are registered from the next-state count, so a pop
            // while full reopens s_ready only on the following cycle.
            localparam int AW = $clog2(DEPTH);

            logic [PAYLOAD_W-1:0] mem [DEPTH];
            logic [LVL_W-1:0]     wptr_q;
            logic [LVL_W-1:0]     rptr_q;
            logic [LVL_W-1:0]     cnt_q;
            logic [LVL_W-1:0]     cnt_next;
            logic                 rdy_q;
            logic                 mv_q;
            logic                 push;
            logic                 pop;

            assign push = s_valid && rdy_q;
            assign pop  = mv_q && m_ready;

            always_comb begin
                cnt_next = cnt_q;
                if (push && !pop) begin
                    cnt_next = cnt_q + 1'b1;
                end else if (pop && !push) begin
                    cnt_next = cnt_q - 1'b1;
                end
            end

            // Storage needs no reset; validity is tracked by the count.
            always_ff @(posedge aclk) begin
                if (push && !areset) begin
                    mem[wptr_q[AW-1:0]] <= s_payload;
                end
            end

            always_ff @(posedge aclk) begin
                if (areset) begin
                    wptr_q <= '0;
                    rptr_q <= '0;
                    cnt_q  <= '0;
                    rdy_q  <= 1'b0;
                    mv_q   <= 1'b0;
                end else begin
                    if (push) begin
                        wptr_q <= (wptr_q == LVL_W'(DEPTH - 1)) ? '0 : wptr_q + 1'b1;
                    end
                    if (pop) begin
                        rptr_q <= (rptr_q == LVL_W'(DEPTH - 1)) ? '0 : rptr_q + 1'b1;
                    end
                    cnt_q <= cnt_next;
                    rdy_q <= (cnt_next != LVL_W'(DEPTH));
                    mv_q  <= (cnt_next != '0);
                end
            end

            // Gate the read data so the output reads zero while empty or in
            // reset, independent of stale storage contents.
            assign s_ready   = rdy_q;
            assign m_valid   = mv_q;
            assign m_payload = mv_q ? mem[rptr_q[AW-1:0]] : '0;
            assign level     = cnt_q;
        end else begin : g_pass
            // Pure wires, except that reset forces both handshakes low.
            assign s_ready   = m_ready && !areset;
            assign m_valid   = s_valid && !areset;
            assign m_payload = areset ? '0 : s_payload;
            assign level     = '0;
        end
    endgenerate

endmodule
